req_ack_responder: RTL and testbench

Handshake responder that drives the request/acknowledge pair consumed by the implication-check stage. It accepts single-cycle request pulses, queues up to MAX_OUTSTANDING of them, and returns one registered acknowledge pulse per accepted request after a fixed latency. Under the default configuration, LATENCY=1 makes the `req |=> ack` relation hold for an isolated request. The block sits directly upstream of the property checker: `req` feeds the antecedent and `ack` feeds the consequent.

---
 rtl/req_ack_pkg.sv | 14 +
 rtl/req_ack_responder_latency_timer.sv | 29 ++
 rtl/req_ack_responder.sv | 103 ++++++++++
 tb/tb_req_ack_responder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/req_ack_pkg.sv
// Shared types and width helper for the request/acknowledge responder.
package req_ack_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

   // Bits needed to hold the values 0..n; used for both the timer and the pending counter.
   function automatic int cnt_w(input int n);
      int w;
      w = 1;
      while ((1 << w) <= n) w++;
      return w;
   endfunction

endpackage

// File: rtl/req_ack_responder_latency_timer.sv
// Loadable down-counter pacing the WAIT state; zero_o flags that the count
// is at zero or lands on zero at the coming edge, so WAIT lasts LATENCY-1 cycles.
module latency_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_value_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)                    cnt_d = load_value_i;
      else if (dec_i && cnt_q != '0) cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == W'(1)) || (cnt_q == '0);

endmodule

// File: rtl/req_ack_responder.sv
// Queues request pulses and returns one registered ack per accepted request after LATENCY edges.
// Define REQ_ACK_RESPONDER_ASSERTIONS_EN to compile in embedded protocol properties.
module req_ack_responder
   import req_ack_pkg::*;
#(
   parameter int LATENCY         = 1,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                req,
   output logic                                ack,
   output logic                                full,
   output logic [cnt_w(MAX_OUTSTANDING)-1:0]   pending,
   output logic                                overflow
);

   localparam int PW = cnt_w(MAX_OUTSTANDING);
   localparam int TW = cnt_w(LATENCY);

   state_e          state_q, state_d;
   logic [PW-1:0]   pending_q, pending_d;
   logic            full_q, full_d;
   logic            overflow_q, overflow_d;
   logic            accept, drop, done;
   logic            tmr_load, tmr_zero;

   latency_timer #(.W(TW)) u_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (tmr_load),
      .load_value_i (TW'(LATENCY - 1)),
      .dec_i        (state_q == WAIT),
      .zero_o       (tmr_zero)
   );

   // Drop decision uses the pre-edge full, so a req at the edge that frees a slot is still lost.
   assign accept = req && !full_q;
   assign drop   = req &&  full_q;
   assign done   = (state_q == ACK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tmr_load   = 1'b0;
      pending_d  = pending_q + PW'(accept) - PW'(done);
      full_d     = (pending_d == PW'(MAX_OUTSTANDING));
      overflow_d = overflow_q | drop;
      case (state_q)
         IDLE: if (accept) begin
            tmr_load = 1'b1;
            state_d  = (LATENCY == 1) ? ACK : WAIT;
         end
         WAIT: if (tmr_zero) state_d = ACK;
         ACK: begin
            if (pending_d != '0) begin
               tmr_load = 1'b1;
               state_d  = (LATENCY == 1) ? ACK : WAIT;
            end else begin
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ack      = (state_q == ACK);
      full     = full_q;
      pending  = pending_q;
      overflow = overflow_q;
   end

`ifdef REQ_ACK_RESPONDER_ASSERTIONS_EN
   // pending is checked in the ACK cycle itself: with LATENCY=1 the previous sample precedes the accept.
   a_ack_pending: assert property (@(posedge clk) disable iff (!rst_n) ack |-> pending != '0);
   a_pend_max:    assert property (@(posedge clk) disable iff (!rst_n) pending <= PW'(MAX_OUTSTANDING));
   a_ovf_cause:   assert property (@(posedge clk) disable iff (!rst_n) $rose(overflow) |-> $past(req && full));
   if (LATENCY > 1) begin : g_gap
      a_ack_gap:  assert property (@(posedge clk) disable iff (!rst_n) ack |=> !ack);
   end
   if (LATENCY == 1) begin : g_l1
      a_req_ack:  assert property (@(posedge clk) disable iff (!rst_n) (req && pending == '0) |=> ack);
   end
   c_req_ack:     cover property (@(posedge clk) disable iff (!rst_n) req ##LATENCY ack);
`else
   localparam bit ASSERTIONS_EN = 1'b0;
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench over five responder configurations with an ack-time scoreboard.
module tb_req_ack_responder;

   function automatic int cfg_lat(input int i);
      case (i)
         0: return 4;
         1: return 1;
         2: return 3;
         3: return 2;
         default: return 5;
      endcase
   endfunction

   function automatic int cfg_max(input int i);
      return (i == 4) ? 2 : 4;
   endfunction

   logic       clk = 1'b0;
   logic [4:0] rst_n;
   logic [4:0] req;
   logic [4:0] ack, full, ovf;
   logic [3:0] pend [5];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      localparam int L = cfg_lat(g);
      localparam int M = cfg_max(g);
      logic [$clog2(M+1)-1:0] p;
      req_ack_responder #(.LATENCY(L), .MAX_OUTSTANDING(M)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n[g]),
         .req      (req[g]),
         .ack      (ack[g]),
         .full     (full[g]),
         .pending  (p),
         .overflow (ovf[g])
      );
      assign pend[g] = 4'(p);
   end

   int nvec = 0, nerr = 0;
   int cur, e, mpend, last;
   bit movf;
   int expq[$];

   task automatic chk(input string tag, input int obs, input int exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s cfg%0d edge %0d: got %0d want %0d", tag, cur, e, obs, exp);
      end
   endtask

   task automatic new_test(input int c);
      cur = c; e = 0; mpend = 0; movf = 0; last = -100;
      expq.delete();
   endtask

   task automatic check_outs();
      chk("ack", int'(ack[cur]), int'(expq.size() != 0 && expq[0] == e + 1));
      chk("pending", int'(pend[cur]), mpend);
      chk("full", int'(full[cur]), int'(mpend == cfg_max(cur)));
      chk("overflow", int'(ovf[cur]), int'(movf));
   endtask

   // One edge: drive req, advance, update scoreboard with expected ack edges, compare.
   task automatic step(input bit r);
      int  L, M, t;
      bit  full_pre;
      L = cfg_lat(cur);
      M = cfg_max(cur);
      req[cur] = r;
      @(posedge clk);
      e++;
      full_pre = (mpend == M);
      if (expq.size() != 0 && expq[0] == e) begin
         void'(expq.pop_front());
         mpend--;
      end
      if (r) begin
         if (full_pre) movf = 1'b1;
         else begin
            t = (e + L > last + L) ? e + L : last + L;
            expq.push_back(t);
            last = t;
            mpend++;
         end
      end
      #1;
      check_outs();
   endtask

   initial begin
      rst_n = '0;
      req   = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = '1;

      // Reset mid-wait: L=4, req at edge 2, reset asserted before edge 4.
      new_test(0);
      step(0); step(1); step(0);
      rst_n[0] = 1'b0;
      #1;
      expq.delete(); mpend = 0; last = -100;
      chk("rst_ack", int'(ack[0]), 0);
      chk("rst_pending", int'(pend[0]), 0);
      chk("rst_full", int'(full[0]), 0);
      chk("rst_overflow", int'(ovf[0]), 0);
      @(posedge clk);
      e++;
      #1;
      check_outs();
      rst_n[0] = 1'b1;
      repeat (8) step(0);

      // Isolated request, then req held high continuously: L=1.
      new_test(1);
      repeat (4) step(0);
      step(1);
      repeat (4) step(0);
      repeat (12) step(1);
      repeat (4) step(0);

      // Long latency: L=3, req at edge 10.
      new_test(2);
      repeat (9) step(0);
      step(1);
      repeat (6) step(0);

      // Burst: L=2, requests at edges 1-4, plus a spaced pair.
      new_test(3);
      repeat (4) step(1);
      repeat (10) step(0);
      step(1); step(0); step(1);
      repeat (6) step(0);

      // Overflow: M=2, L=5, three back-to-back requests, then long idle.
      new_test(4);
      repeat (3) step(1);
      repeat (30) step(0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
